tile_scheduler: RTL

TILE_SCHEDULER -- requirements
Module: tile_scheduler

---
 rtl/tile_scheduler_pkg.sv | 19 +
 rtl/tile_scheduler_len_calc.sv | 25 ++
 rtl/tile_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tile_scheduler_pkg.sv
// Shared accelerator types: layer-type codes and the tile scheduler FSM states.
package tile_scheduler_pkg;

    typedef enum logic [1:0] {
        LT_POINTWISE = 2'd0,
        LT_DEPTHWISE = 2'd1,
        LT_STANDARD  = 2'd2,
        LT_RESERVED  = 2'd3
    } layer_type_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/tile_scheduler_len_calc.sv
// Clamps one tile dimension to the remaining channels and flags the last tile of the loop.
module tile_len_calc #(
    parameter int unsigned CH_W   = 11,
    parameter int unsigned TILE_W = 8
) (
    input  logic [CH_W-1:0]   base,
    input  logic [TILE_W-1:0] size,
    input  logic [CH_W-1:0]   total,
    output logic [TILE_W-1:0] len,
    output logic              last
);

    // One extra bit over the wider operand so base + size never wraps.
    localparam int unsigned SUM_W = ((CH_W > TILE_W) ? CH_W : TILE_W) + 1;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] remain;

    assign sum    = SUM_W'(base) + SUM_W'(size);
    assign remain = SUM_W'(total) - SUM_W'(base);
    assign last   = (sum >= SUM_W'(total));
    // On the last tile the remainder is at most size, so it fits TILE_W.
    assign len    = last ? TILE_W'(remain) : size;

endmodule

// File: rtl/tile_scheduler.sv
// Walks a layer's output/input channel space in tiles (K outer, D inner) and
// hands one descriptor at a time to the datapath.
module tile_scheduler
    import tile_scheduler_pkg::*;
#(
    parameter int unsigned CH_W   = 11,
    parameter int unsigned TILE_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        layer_type_i,
    input  logic [CH_W-1:0]   in_D_i,
    input  logic [CH_W-1:0]   out_K_i,
    input  logic [TILE_W-1:0] tile_D_i,
    input  logic [TILE_W-1:0] tile_K_i,
    output logic              tile_valid_o,
    input  logic              tile_ready_i,
    output logic [CH_W-1:0]   d_base_o,
    output logic [CH_W-1:0]   k_base_o,
    output logic [TILE_W-1:0] d_len_o,
    output logic [TILE_W-1:0] k_len_o,
    output logic              first_d_o,
    output logic              last_d_o,
    input  logic              tile_done_i,
    output logic              busy_o,
    output logic              layer_done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  tile_cnt_o
);

    state_e            state;
    state_e            state_next;
    layer_type_e       cfg_type;
    logic [CH_W-1:0]   cfg_in_d;
    logic [CH_W-1:0]   cfg_out_k;
    logic [TILE_W-1:0] cfg_tile_d;
    logic [TILE_W-1:0] cfg_tile_k;
    logic [CH_W-1:0]   d_base;
    logic [CH_W-1:0]   k_base;
    logic [TILE_W-1:0] d_len;
    logic [TILE_W-1:0] k_len;
    logic              d_last;
    logic              k_last;
    logic              is_dw;
    logic              cfg_bad;
    logic              layer_end;
    logic              start_ok;

    tile_len_calc #(.CH_W(CH_W), .TILE_W(TILE_W)) u_d_len (
        .base  (d_base),
        .size  (cfg_tile_d),
        .total (cfg_in_d),
        .len   (d_len),
        .last  (d_last)
    );

    tile_len_calc #(.CH_W(CH_W), .TILE_W(TILE_W)) u_k_len (
        .base  (k_base),
        .size  (cfg_tile_k),
        .total (cfg_out_k),
        .len   (k_len),
        .last  (k_last)
    );

    assign is_dw     = (cfg_type == LT_DEPTHWISE);
    assign start_ok  = (state == ST_IDLE) && start_i && !abort_i;
    assign layer_end = d_last && (is_dw || k_last);
    // Depthwise layers never look at the K configuration.
    assign cfg_bad   = (tile_D_i == '0) || (in_D_i == '0) ||
                       (layer_type_i == LT_RESERVED) ||
                       ((layer_type_i != LT_DEPTHWISE) &&
                        ((tile_K_i == '0) || (out_K_i == '0)));

    // Descriptor is zeroed while idle so reset and idle present all-zero outputs.
    assign busy_o       = (state != ST_IDLE);
    assign tile_valid_o = (state == ST_ISSUE) && !abort_i;
    assign d_base_o     = busy_o ? d_base : '0;
    assign k_base_o     = !busy_o ? '0 : (is_dw ? d_base : k_base);
    assign d_len_o      = busy_o ? d_len : '0;
    assign k_len_o      = !busy_o ? '0 : (is_dw ? d_len : k_len);
    assign first_d_o    = busy_o && (d_base == '0);
    assign last_d_o     = busy_o && d_last;

    // Next-state logic; abort overrides every other event.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_i) state_next = cfg_bad ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (tile_ready_i) state_next = ST_WAIT;
            ST_WAIT:  if (tile_done_i) state_next = ST_NEXT;
            ST_NEXT:  state_next = layer_end ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort_i) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cfg_type     <= LT_POINTWISE;
            cfg_in_d     <= '0;
            cfg_out_k    <= '0;
            cfg_tile_d   <= '0;
            cfg_tile_k   <= '0;
            d_base       <= '0;
            k_base       <= '0;
            layer_done_o <= 1'b0;
            err_o        <= 1'b0;
            tile_cnt_o   <= '0;
        end else begin
            state        <= state_next;
            layer_done_o <= (state_next == ST_DONE);
            if (start_ok) begin
                cfg_type   <= layer_type_e'(layer_type_i);
                cfg_in_d   <= in_D_i;
                cfg_out_k  <= out_K_i;
                cfg_tile_d <= tile_D_i;
                cfg_tile_k <= tile_K_i;
                d_base     <= '0;
                k_base     <= '0;
                err_o      <= cfg_bad;
                tile_cnt_o <= '0;
            end
            if ((state == ST_WAIT) && tile_done_i && !abort_i && (tile_cnt_o != '1)) begin
                tile_cnt_o <= tile_cnt_o + CNT_W'(1);
            end
            // Advance D; wrap to the next K tile after the last D tile.
            if ((state == ST_NEXT) && !abort_i) begin
                if (d_last) begin
                    d_base <= '0;
                    k_base <= k_base + CH_W'(cfg_tile_k);
                end else begin
                    d_base <= d_base + CH_W'(cfg_tile_d);
                end
            end
        end
    end

endmodule
